branch_ctrl: RTL
================

# branch_ctrl

Decode-stage branch controller for the 5-stage pipelined MIPS core. It decodes the branch instruction in ID and drives the 3-bit operation code of the ID-stage branch comparator. It sequences hazard stalls until both comparator operands are valid, selects MEM-to-ID forwarding, and on resolution redirects the PC and flushes the wrong-path fetch. It also keeps saturating branch statistics counters for performance analysis.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `OpD`  in  6  opcode of the instruction in ID
- `RsD`, `RtD`  in  5 each  source register fields in ID
- `RegWriteE`, `MemtoRegE`  in  1 each  EX-stage instruction writes a register / is a load
- `WriteRegE`  in  5  EX-stage destination register
- `RegWriteM`, `MemtoRegM`  in  1 each  MEM-stage instruction writes a register / is a load
- `WriteRegM`  in  5  MEM-stage destination register
- `CompD`  in  1  comparator result for the current `CompOpD`
- `CompOpD`  out  3  comparator operation code
- `ForwardAD`, `ForwardBD`  out  1 each  select MEM-stage ALU result for comparator input A/B
- `StallF`, `StallD`, `FlushE`  out  1 each  hold PC, hold IF/ID, bubble ID/EX
- `PCSrcD`  out  1  take branch target this cycle
- `FlushD`  out  1  clear IF/ID; equals `PCSrcD`
- `BrCnt`, `TakenCnt`, `StallCnt`  out  16 each  resolved branches, taken branches, branch-stall cycles

## Operation
- Branch decode (`BranchD`, combinational):
  - 000100 → BEQ, code 000
  - 000101 → BNE, code 001
  - 000111 → BGTZ, code 011
  - 000110 → BLEZ, code 100
  - 000001 with `RtD` = 00001 → BGEZ, code 010
  - 000001 with `RtD` = 00000 → BLTZ, code 101
  - Anything else: `BranchD` = 0 and `CompOpD` = 000.
- Used operands: BEQ and BNE use Rs and Rt. All other branches use Rs only.
- A used register equal to 0 never creates a hazard and never forwards.
- Requirement `need` per used operand; take the maximum over the used operands:
  - 2 if it matches `WriteRegE` with `RegWriteE` and `MemtoRegE` set.
  - 1 if it matches `WriteRegE` with `RegWriteE` set and `MemtoRegE` clear.
  - 1 if it matches `WriteRegM` with `RegWriteM` and `MemtoRegM` set.
  - 0 otherwise.
- `ForwardAD` = `RsD` ≠ 0, `RsD` = `WriteRegM`, `RegWriteM` set and `MemtoRegM` clear. `ForwardBD` is the same rule applied to `RtD`, and is asserted only for BEQ/BNE.
- The register file provides write-before-read bypass, so WB-stage producers need no forwarding here.
- FSM states:
  - IDLE:
    - If `BranchD` and `need` = 0: resolve this cycle, stay in IDLE.
    - If `BranchD` and `need` > 0: assert stall this cycle, load `cnt` = `need` − 1, go to WAIT.
  - WAIT:
    - If `cnt` ≠ 0: assert stall, decrement `cnt`.
    - If `cnt` = 0: resolve this cycle, go to IDLE.
- Stall: `StallF` = `StallD` = `FlushE` = 1, `PCSrcD` = 0.
- Resolve: stall outputs are 0, `PCSrcD` = `FlushD` = `CompD`.
- `need` is evaluated only in IDLE. Stalls advance producers deterministically, so WAIT does not re-evaluate it.
- Counters saturate at 0xFFFF:
  - `BrCnt` increments once per resolve.
  - `TakenCnt` increments on a resolve with `CompD` = 1.
  - `StallCnt` increments once per stall cycle.
- The FSM never creates a stall for non-branch instructions. Load-use stalls for other instructions belong to the hazard unit.

## Timing
- Decode, `CompOpD`, forwarding selects, stall and resolve outputs are combinational from the inputs and the current state. Counters and the FSM are registered.
- Branch latency in ID: 1 + `need` cycles; the redirect appears in the final cycle.
- Reset values: state IDLE, `cnt` = 0, all counters 0. All outputs are 0 while `rst` is high, even if a branch is present.
- Reset asserted in WAIT: state IDLE on the next edge, counters cleared, and no resolve is issued for the aborted branch.
- Simultaneous events: a reset edge takes priority over counter increments. A saturated counter holds 0xFFFF.
- A branch whose `CompD` = 0 still counts in `BrCnt` and takes 0 in `TakenCnt`.

## Test plan
- BEQ, no hazards, `CompD` = 1 → same cycle: `CompOpD` = 000, `PCSrcD` = `FlushD` = 1, no stall; `BrCnt` = 1, `TakenCnt` = 1.
- BNE with `RsD` = 8, EX has ALU write to r8 → cycle 0: stall; cycle 1: `ForwardAD` = 1, resolve with `CompD`; `StallCnt` = 1.
- BGTZ (000111), `RsD` = 9, EX has a load to r9 → two stall cycles, resolve in cycle 2 with `ForwardAD` = 0; `StallCnt` = 2.
- BLTZ (op 000001, `RtD` = 0) while EX writes r0 or writes `RtD` → no stall, `CompOpD` = 101, `ForwardBD` = 0.
- `rst` asserted in the first WAIT cycle of a 2-stall load hazard → next cycle all outputs 0, counters 0, state IDLE.
- 65 536 back-to-back taken branches → `BrCnt` = `TakenCnt` = 0xFFFF, held at that value.

Source files
------------

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: branch decode, comparator opcode, MEM->ID
// forwarding selects, hazard stall sequencing, PC redirect and branch statistics.
module branch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  OpD,
   input  logic [4:0]  RsD,
   input  logic [4:0]  RtD,
   input  logic        RegWriteE,
   input  logic        MemtoRegE,
   input  logic [4:0]  WriteRegE,
   input  logic        RegWriteM,
   input  logic        MemtoRegM,
   input  logic [4:0]  WriteRegM,
   input  logic        CompD,
   output logic [2:0]  CompOpD,
   output logic        ForwardAD,
   output logic        ForwardBD,
   output logic        StallF,
   output logic        StallD,
   output logic        FlushE,
   output logic        PCSrcD,
   output logic        FlushD,
   output logic [15:0] BrCnt,
   output logic [15:0] TakenCnt,
   output logic [15:0] StallCnt
);

   typedef enum logic [0:0] {StIdle, StWait} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] br_cnt_q, br_cnt_d;
   logic [15:0] taken_cnt_q, taken_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   logic        branch_d;
   logic        use_rt;
   logic [2:0]  comp_op;
   logic [1:0]  need_rs, need_rt, need;
   logic        stall, resolve;

   // Cycles an operand must wait before the comparator sees a valid value.
   function automatic logic [1:0] op_need(input logic [4:0] r,
                                          input logic       rw_e,
                                          input logic       m2r_e,
                                          input logic [4:0] wr_e,
                                          input logic       rw_m,
                                          input logic       m2r_m,
                                          input logic [4:0] wr_m);
      logic [1:0] n;
      n = 2'd0;
      if (r != 5'd0) begin
         if (rw_e && m2r_e && (r == wr_e))       n = 2'd2;
         else if (rw_e && !m2r_e && (r == wr_e)) n = 2'd1;
         else if (rw_m && m2r_m && (r == wr_m))  n = 2'd1;
      end
      return n;
   endfunction

   // Branch decode and comparator opcode.
   always_comb begin
      branch_d = 1'b1;
      use_rt   = 1'b0;
      comp_op  = 3'b000;
      case (OpD)
         6'b000100: begin comp_op = 3'b000; use_rt = 1'b1; end
         6'b000101: begin comp_op = 3'b001; use_rt = 1'b1; end
         6'b000111: comp_op = 3'b011;
         6'b000110: comp_op = 3'b100;
         6'b000001: begin
            if (RtD == 5'b00001)      comp_op = 3'b010;
            else if (RtD == 5'b00000) comp_op = 3'b101;
            else                      branch_d = 1'b0;
         end
         default: branch_d = 1'b0;
      endcase
   end

   // Hazard requirement: maximum over the operands the branch actually reads.
   always_comb begin
      need_rs = op_need(RsD, RegWriteE, MemtoRegE, WriteRegE, RegWriteM, MemtoRegM, WriteRegM);
      need_rt = op_need(RtD, RegWriteE, MemtoRegE, WriteRegE, RegWriteM, MemtoRegM, WriteRegM);
      need    = (use_rt && (need_rt > need_rs)) ? need_rt : need_rs;
   end

   // Stall/resolve sequencing; need is only sampled on entry from idle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      resolve = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (branch_d) begin
               if (need == 2'd0) begin
                  resolve = 1'b1;
               end else begin
                  stall   = 1'b1;
                  cnt_d   = need - 2'd1;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            if (cnt_q != 2'd0) begin
               stall = 1'b1;
               cnt_d = cnt_q - 2'd1;
            end else begin
               resolve = 1'b1;
               state_d = StIdle;
            end
         end
      endcase
      if (rst) begin
         stall   = 1'b0;
         resolve = 1'b0;
      end
   end

   // Saturating statistics counters.
   always_comb begin
      br_cnt_d    = br_cnt_q;
      taken_cnt_d = taken_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (resolve && (br_cnt_q != 16'hFFFF))              br_cnt_d    = br_cnt_q + 16'd1;
      if (resolve && CompD && (taken_cnt_q != 16'hFFFF))  taken_cnt_d = taken_cnt_q + 16'd1;
      if (stall && (stall_cnt_q != 16'hFFFF))             stall_cnt_d = stall_cnt_q + 16'd1;
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 2'd0;
         br_cnt_q    <= 16'd0;
         taken_cnt_q <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Outputs, forced to zero while reset is held.
   always_comb begin
      CompOpD   = rst ? 3'b000 : comp_op;
      ForwardAD = !rst && (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM && !MemtoRegM;
      ForwardBD = !rst && branch_d && use_rt && (RtD != 5'd0) && (RtD == WriteRegM) &&
                  RegWriteM && !MemtoRegM;
      StallF    = stall;
      StallD    = stall;
      FlushE    = stall;
      PCSrcD    = resolve && CompD;
      FlushD    = resolve && CompD;
      BrCnt     = rst ? 16'd0 : br_cnt_q;
      TakenCnt  = rst ? 16'd0 : taken_cnt_q;
      StallCnt  = rst ? 16'd0 : stall_cnt_q;
   end

endmodule
